// File: rtl/layer3_reader_pkg.sv
// Shared types and helpers for the layer-3 result read sequencer.
package layer3_reader_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

    // True when (row, col) is the bottom-right corner of a width x width map.
    function automatic logic is_last_coord(
        input logic [ADDR_W-1:0] row,
        input logic [ADDR_W-1:0] col,
        input int unsigned       width
    );
        logic [ADDR_W-1:0] last_idx;
        last_idx = ADDR_W'(width - 1);
        return (row == last_idx) && (col == last_idx);
    endfunction

endpackage

// File: rtl/layer3_raster_addr_gen.sv
// Row/column raster counter for a WIDTH x WIDTH map with selectable scan order.
module layer3_raster_addr_gen
    import layer3_reader_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              col_major,
    input  logic              advance,
    output logic [ADDR_W-1:0] row_addr,
    output logic [ADDR_W-1:0] col_addr,
    output logic              at_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] row_reg, col_reg, row_next, col_next;
    logic [CNT_W-1:0] fast_cnt, slow_cnt, fast_next, slow_next;
    logic             col_major_reg;

    // The "fast" counter is col in row-major order and row in column-major order.
    always_comb begin
        fast_cnt  = col_major_reg ? row_reg : col_reg;
        slow_cnt  = col_major_reg ? col_reg : row_reg;
        fast_next = (fast_cnt == LAST_IDX) ? '0 : fast_cnt + ONE;
        slow_next = slow_cnt;
        if (fast_cnt == LAST_IDX) begin
            slow_next = (slow_cnt == LAST_IDX) ? '0 : slow_cnt + ONE;
        end
        row_next = col_major_reg ? fast_next : slow_next;
        col_next = col_major_reg ? slow_next : fast_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_reg       <= '0;
            col_reg       <= '0;
            col_major_reg <= 1'b0;
        end else if (clear) begin
            row_reg       <= '0;
            col_reg       <= '0;
            col_major_reg <= col_major;
        end else if (advance) begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row_addr = ADDR_W'(row_reg);
    assign col_addr = ADDR_W'(col_reg);
    assign at_last  = is_last_coord(row_addr, col_addr, WIDTH);

endmodule

// File: rtl/layer3_result_reader.sv
// Streams the whole layer-3 result map out of memory in raster order through a
// registered valid/ready port, flagging the last element and pulsing done.
`ifndef LAYER3_OUTPUT_LENGTH
`define LAYER3_OUTPUT_LENGTH 8
`endif
`ifndef LAYER4_WIDTH
`define LAYER4_WIDTH 4
`endif

module layer3_result_reader
    import layer3_reader_pkg::*;
#(
    parameter int DATA_W = `LAYER3_OUTPUT_LENGTH,
    parameter int WIDTH  = `LAYER4_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_major,
    output logic [15:0]       read_row_addr,
    output logic [15:0]       read_col_addr,
    output logic              layer3_result_read_signal,
    input  logic [DATA_W-1:0] layer3_result_output,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    reader_state_t     state_reg, state_next;
    logic              load;
    logic              read_en;
    logic              addr_clear;
    logic              word_release;
    logic              at_last;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              done_reg;

    layer3_raster_addr_gen #(
        .WIDTH(WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (addr_clear),
        .col_major(col_major),
        .advance  (read_en),
        .row_addr (read_row_addr),
        .col_addr (read_col_addr),
        .at_last  (at_last)
    );

    // The output register can take a new word when empty or being drained.
    assign load = !out_valid_reg || out_ready;

    always_comb begin
        state_next   = state_reg;
        read_en      = 1'b0;
        addr_clear   = 1'b0;
        word_release = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_clear = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    read_en = 1'b1;
                    if (at_last) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_ready) begin
                    word_release = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (read_en) begin
                out_data_reg  <= layer3_result_output;
                out_valid_reg <= 1'b1;
                out_last_reg  <= at_last;
            end else if (word_release) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign layer3_result_read_signal = read_en;
    assign out_data                  = out_data_reg;
    assign out_valid                 = out_valid_reg;
    assign out_last                  = out_last_reg;
    assign done                      = done_reg;
    assign busy                      = (state_reg != IDLE);

endmodule
